rr_arbiter_n: RTL and testbench

Parametrised N-channel round-robin arbiter with a registered output stage, placed between the per-channel request pipelines and the shared resource. It selects one pending request per cycle, forwards its address, ID and channel index to the resource over a valid/ready handshake, and stalls the losing channels. Flush-matched requests are dropped rather than stalled, so a flushing channel always drains. It supersedes the fixed two-channel arbiter and address/ID muxing in the top level.

---
 rtl/rr_arbiter_n.sv | 141 ++++++++++++++
 tb/tb_rr_arbiter_n.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
// N-channel round-robin arbiter with a registered output stage.
// Flush-matched requests are dropped instead of stalled; a held entry hit by a flush is killed.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module rr_arbiter_n #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = `ADDRESS_WIDTH,
  parameter int ID_W   = `ID_WIDTH,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*ADDR_W-1:0] in_address,
  input  logic [NUM_CH*ID_W-1:0]   in_id,
  input  logic [NUM_CH-1:0]        in_flush,
  input  logic [NUM_CH*ID_W-1:0]   in_flush_id,
  output logic [NUM_CH-1:0]        out_stall,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_address,
  output logic [ID_W-1:0]          out_id,
  output logic [CH_W-1:0]          out_choice,
  input  logic                     in_ready,
  output logic [15:0]              out_drop_count
);

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [ID_W-1:0]   id_a    [NUM_CH];
  logic [ID_W-1:0]   fid_a   [NUM_CH];
  logic [NUM_CH-1:0] flushed;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CH_W-1:0]   choice_q, choice_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [15:0]       drop_q, drop_d;

  logic              kill;
  logic              load;
  logic              found;
  logic [CH_W-1:0]   winner;
  logic [31:0]       drop_inc;
  logic [31:0]       drop_sum;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      addr_a[i]  = in_address[i*ADDR_W +: ADDR_W];
      id_a[i]    = in_id[i*ID_W +: ID_W];
      fid_a[i]   = in_flush_id[i*ID_W +: ID_W];
      flushed[i] = in_flush[i] && (fid_a[i] == id_a[i]);
    end
  end

  assign elig = in_valid & ~flushed;
  assign kill = valid_q && !in_ready && in_flush[choice_q] && (fid_a[choice_q] == id_q);
  assign load = !valid_q || in_ready || kill;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    int unsigned idx;
    logic [CH_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // No grant is issued while reset holds the registers.
  always_comb begin
    grant = '0;
    if (load && found && !reset) grant[winner] = 1'b1;
  end

  assign out_stall = elig & ~grant;

  always_comb begin
    drop_inc = 32'(kill);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      drop_inc = drop_inc + 32'(in_valid[i] & flushed[i]);
    end
    drop_sum = {16'b0, drop_q} + drop_inc;
    drop_d   = (drop_sum > 32'h0000_FFFF) ? '1 : drop_sum[15:0];
  end

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    id_d     = id_q;
    choice_d = choice_q;
    ptr_d    = ptr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        addr_d   = addr_a[winner];
        id_d     = id_a[winner];
        choice_d = winner;
        ptr_d    = winner;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      addr_q   <= '0;
      id_q     <= '0;
      choice_q <= '0;
      ptr_q    <= CH_W'(NUM_CH - 1);
      drop_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      choice_q <= choice_d;
      ptr_q    <= ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_address    = addr_q;
  assign out_id         = id_q;
  assign out_choice     = choice_q;
  assign out_drop_count = drop_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed table-driven bench for rr_arbiter_n (4 channels, 8-bit address, 4-bit ID).
module tb_rr_arbiter_n;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_address;
  logic [15:0] in_id;
  logic [3:0]  in_flush;
  logic [15:0] in_flush_id;
  logic [3:0]  out_stall;
  logic        out_valid;
  logic [7:0]  out_address;
  logic [3:0]  out_id;
  logic [1:0]  out_choice;
  logic        in_ready;
  logic [15:0] out_drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  rr_arbiter_n #(.NUM_CH(4), .ADDR_W(8), .ID_W(4), .CH_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_address(in_address),
    .in_id(in_id), .in_flush(in_flush), .in_flush_id(in_flush_id),
    .out_stall(out_stall), .out_valid(out_valid), .out_address(out_address),
    .out_id(out_id), .out_choice(out_choice), .in_ready(in_ready),
    .out_drop_count(out_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] addr;
    logic [15:0] id;
    logic [3:0]  flush;
    logic [15:0] fid;
    logic        ready;
    logic [3:0]  e_stall;
    logic        e_valid;
    logic [7:0]  e_addr;
    logic [3:0]  e_id;
    logic [1:0]  e_ch;
    logic [15:0] e_drop;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] a, input logic [15:0] i,
                              input logic [3:0] f, input logic [15:0] fi, input logic r,
                              input logic [3:0] es, input logic ev, input logic [7:0] ea,
                              input logic [3:0] ei, input logic [1:0] ec, input logic [15:0] ed);
    vec_t t;
    t.valid = v; t.addr = a; t.id = i; t.flush = f; t.fid = fi; t.ready = r;
    t.e_stall = es; t.e_valid = ev; t.e_addr = ea; t.e_id = ei; t.e_ch = ec; t.e_drop = ed;
    return t;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [15:0] i,
                       input logic [3:0] f, input logic [15:0] fi, input logic r);
    in_valid = v; in_address = a; in_id = i; in_flush = f; in_flush_id = fi; in_ready = r;
  endtask

  localparam logic [31:0] A0 = 32'h4030_2010;
  localparam logic [31:0] A1 = 32'h405A_2010;
  localparam logic [15:0] I0 = 16'h4321;

  initial begin
    // fairness: all valid, grants 0,1,2,3,0
    tbl[0]  = mk(4'b1111, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b1110, 1'b1, 8'h10, 4'd1, 2'd0, 16'd0);
    tbl[1]  = mk(4'b1111, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b1101, 1'b1, 8'h20, 4'd2, 2'd1, 16'd0);
    tbl[2]  = mk(4'b1111, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b1011, 1'b1, 8'h30, 4'd3, 2'd2, 16'd0);
    tbl[3]  = mk(4'b1111, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b0111, 1'b1, 8'h40, 4'd4, 2'd3, 16'd0);
    tbl[4]  = mk(4'b1111, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b1110, 1'b1, 8'h10, 4'd1, 2'd0, 16'd0);
    // back-pressure: ch2 addr 5A held three cycles while ch0 stalls
    tbl[5]  = mk(4'b0100, A1, I0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'h5A, 4'd3, 2'd2, 16'd0);
    tbl[6]  = mk(4'b0001, A1, I0, 4'b0000, 16'h0000, 1'b0, 4'b0001, 1'b1, 8'h5A, 4'd3, 2'd2, 16'd0);
    tbl[7]  = mk(4'b0001, A1, I0, 4'b0000, 16'h0000, 1'b0, 4'b0001, 1'b1, 8'h5A, 4'd3, 2'd2, 16'd0);
    tbl[8]  = mk(4'b0001, A1, I0, 4'b0000, 16'h0000, 1'b0, 4'b0001, 1'b1, 8'h5A, 4'd3, 2'd2, 16'd0);
    tbl[9]  = mk(4'b0001, A1, I0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'h10, 4'd1, 2'd0, 16'd0);
    // flush of pending ch1 ID 7
    tbl[10] = mk(4'b0010, A0, 16'h4371, 4'b0010, 16'h0070, 1'b1, 4'b0000, 1'b0, 8'h00, 4'd0, 2'd0, 16'd1);
    // kill: ch3 ID 9 held, flushed with in_ready=0 while ch0 eligible
    tbl[11] = mk(4'b1000, A0, 16'h9321, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'h40, 4'd9, 2'd3, 16'd1);
    tbl[12] = mk(4'b0001, A0, 16'h9321, 4'b1000, 16'h9000, 1'b0, 4'b0000, 1'b1, 8'h10, 4'd1, 2'd0, 16'd2);
    // same flush with in_ready=1: ID 9 transfers, no kill
    tbl[13] = mk(4'b1000, A0, 16'h9321, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'h40, 4'd9, 2'd3, 16'd2);
    tbl[14] = mk(4'b0001, A0, 16'h9321, 4'b1000, 16'h9000, 1'b1, 4'b0000, 1'b1, 8'h10, 4'd1, 2'd0, 16'd2);
    // wrap 3 -> 0, idle, then ptr still 0 so ch1 beats ch0
    tbl[15] = mk(4'b1000, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'h40, 4'd4, 2'd3, 16'd2);
    tbl[16] = mk(4'b0001, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'h10, 4'd1, 2'd0, 16'd2);
    tbl[17] = mk(4'b0000, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'd0, 2'd0, 16'd2);
    tbl[18] = mk(4'b0011, A0, I0, 4'b0000, 16'h0000, 1'b1, 4'b0001, 1'b1, 8'h20, 4'd2, 2'd1, 16'd2);
    // all four flushed at once: drop count +4
    tbl[19] = mk(4'b1111, A0, I0, 4'b1111, I0,       1'b1, 4'b0000, 1'b0, 8'h00, 4'd0, 2'd0, 16'd6);

    reset = 1'b1;
    drive(4'b1111, A0, I0, 4'b0000, 16'h0000, 1'b1);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(out_address), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_choice", 32'(out_choice), 32'd0);
    chk("rst_drop", 32'(out_drop_count), 32'd0);
    chk("rst_stall", 32'(out_stall), 32'hF);
    #10;
    reset = 1'b0;

    for (int v = 0; v < NV; v++) begin
      drive(tbl[v].valid, tbl[v].addr, tbl[v].id, tbl[v].flush, tbl[v].fid, tbl[v].ready);
      #1;
      chk($sformatf("v%0d_stall", v), 32'(out_stall), 32'(tbl[v].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'(tbl[v].e_valid));
      chk($sformatf("v%0d_drop", v), 32'(out_drop_count), 32'(tbl[v].e_drop));
      if (tbl[v].e_valid) begin
        chk($sformatf("v%0d_addr", v), 32'(out_address), 32'(tbl[v].e_addr));
        chk($sformatf("v%0d_id", v), 32'(out_id), 32'(tbl[v].e_id));
        chk($sformatf("v%0d_choice", v), 32'(out_choice), 32'(tbl[v].e_ch));
      end
    end

    // asynchronous reset while an entry is held under back-pressure
    drive(4'b0100, A0, I0, 4'b0000, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    drive(4'b0000, A0, I0, 4'b0000, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_choice", 32'(out_choice), 32'd2);
    #2;
    drive(4'b1111, A0, I0, 4'b0001, 16'h0001, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_drop", 32'(out_drop_count), 32'd0);
    chk("arst_stall", 32'(out_stall), 32'hE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'b1111, A0, I0, 4'b0000, 16'h0000, 1'b1);
    #1;
    chk("post_rst_stall", 32'(out_stall), 32'hE);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_choice", 32'(out_choice), 32'd0);
    chk("post_rst_addr", 32'(out_address), 32'h10);
    chk("post_rst_drop", 32'(out_drop_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
